// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one busywait-style backing memory among N_PORTS cache ports.
// Round-robin grant, one transfer in flight, per-access watchdog with a
// sticky timeout flag. Each port sees the same read/write/busywait handshake
// it would see from a private memory.
module mem_port_arbiter #(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [N_PORTS-1:0]          port_read,
    input  logic [N_PORTS-1:0]          port_write,
    input  logic [N_PORTS*ADDR_W-1:0]   port_address,
    input  logic [N_PORTS*DATA_W-1:0]   port_writedata,
    output logic [DATA_W-1:0]           port_readdata,
    output logic [N_PORTS-1:0]          port_busywait,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [DATA_W-1:0]           mem_writedata,
    input  logic [DATA_W-1:0]           mem_readdata,
    input  logic                        mem_busywait,
    output logic                        timeout_err
);

    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_PORTS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Port index reached by stepping 'off' places past 'base', wrapping.
    function automatic logic [PTR_W-1:0] f_wrap_idx(input logic [PTR_W-1:0] base,
                                                   input int               off);
        return PTR_W'((int'(base) + off) % N_PORTS);
    endfunction

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [PTR_W-1:0]       r_grant;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_mem_read;
    logic                   r_mem_write;
    logic [ADDR_W-1:0]      r_mem_address;
    logic [DATA_W-1:0]      r_mem_writedata;
    logic [DATA_W-1:0]      r_port_readdata;
    logic                   r_timeout_err;

    logic [N_PORTS-1:0]     w_req;
    logic                   w_grant_found;
    logic [PTR_W-1:0]       w_grant_idx;
    logic [PTR_W-1:0]       w_cand;
    logic                   w_sel_write;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [DATA_W-1:0]      w_sel_wdata;
    logic                   w_do_grant;
    logic                   w_do_done;
    logic                   w_do_timeout;

    assign w_req       = port_read | port_write;
    assign w_sel_write = port_write[w_grant_idx];
    assign w_sel_addr  = port_address[int'(w_grant_idx)*ADDR_W +: ADDR_W];
    assign w_sel_wdata = port_writedata[int'(w_grant_idx)*DATA_W +: DATA_W];

    assign mem_read      = r_mem_read;
    assign mem_write     = r_mem_write;
    assign mem_address   = r_mem_address;
    assign mem_writedata = r_mem_writedata;
    assign port_readdata = r_port_readdata;
    assign timeout_err   = r_timeout_err;

    // Round-robin search: first requester after the last granted port.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_cand        = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            w_cand = f_wrap_idx(r_rr_ptr, k);
            if (!w_grant_found && w_req[w_cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand;
            end else begin
                w_grant_found = w_grant_found;
            end
        end
    end

    // Stall every requester except the one whose response cycle this is.
    always_comb begin
        port_busywait = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            port_busywait[i] = w_req[i] & ~((r_state == ST_RESP) && (r_grant == PTR_W'(i)));
        end
    end

    // Next-state decode and the one-cycle control strobes that drive the datapath.
    always_comb begin
        w_state_nxt  = r_state;
        w_do_grant   = 1'b0;
        w_do_done    = 1'b0;
        w_do_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_found) begin
                    w_do_grant  = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // The memory gets one cycle to raise busywait before a low
                // busywait can be trusted as completion.
                if ((r_cnt >= CNT_TWO) && !mem_busywait) begin
                    w_do_done   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (r_cnt >= CNT_MAX) begin
                    w_do_timeout = 1'b1;
                    w_state_nxt  = ST_RESP;
                end else begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant latching, memory strobes, access counter, read return and watchdog flag.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rr_ptr        <= PTR_LAST;
            r_grant         <= '0;
            r_cnt           <= CNT_ZERO;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
            r_port_readdata <= '0;
            r_timeout_err   <= 1'b0;
        end else begin
            if (w_do_grant) begin
                r_grant         <= w_grant_idx;
                r_rr_ptr        <= w_grant_idx;
                r_mem_read      <= ~w_sel_write;
                r_mem_write     <= w_sel_write;
                r_mem_address   <= w_sel_addr;
                r_mem_writedata <= w_sel_wdata;
                r_cnt           <= CNT_ONE;
            end else if (w_do_done) begin
                if (r_mem_read) begin
                    r_port_readdata <= mem_readdata;
                end else begin
                    r_port_readdata <= r_port_readdata;
                end
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
            end else if (w_do_timeout) begin
                r_timeout_err <= 1'b1;
                r_mem_read    <= 1'b0;
                r_mem_write   <= 1'b0;
            end else if (r_state == ST_ACCESS) begin
                r_cnt <= r_cnt + CNT_ONE;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a busywait memory model, a table of single
// transfers, hand-written multi-cycle sequences, and a randomized two-port
// run checked against a shadow memory and a round-robin fairness rule.
module tb_mem_port_arbiter;

    localparam int NP = 2;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [NP-1:0]     port_read;
    logic [NP-1:0]     port_write;
    logic [NP*AW-1:0]  port_address;
    logic [NP*DW-1:0]  port_writedata;
    logic [DW-1:0]     port_readdata;
    logic [NP-1:0]     port_busywait;
    logic              mem_read;
    logic              mem_write;
    logic [AW-1:0]     mem_address;
    logic [DW-1:0]     mem_writedata;
    logic [DW-1:0]     mem_readdata;
    logic              mem_busywait;
    logic              timeout_err;

    int errors = 0;
    int checks = 0;

    // memory model controls
    int  busy_cfg  = 0;
    bit  rand_busy = 1'b0;
    bit  stuck     = 1'b0;
    int  mem_cnt   = 0;
    int  busy_cur  = 0;
    logic [DW-1:0] mem_arr [64];

    mem_port_arbiter #(.N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET(RESET),
        .port_read(port_read), .port_write(port_write),
        .port_address(port_address), .port_writedata(port_writedata),
        .port_readdata(port_readdata), .port_busywait(port_busywait),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
        .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_val(input int a);
        if (a == 5) return 32'hDEADBEEF;
        return 32'h5A00_0000 + 32'(a) * 32'h0001_0203;
    endfunction

    // Busywait memory: busy for busy_cur cycles of an access, then ready.
    assign mem_busywait = stuck | ((mem_read | mem_write) && (mem_cnt < busy_cur));
    assign mem_readdata = mem_arr[mem_address];

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mem_cnt <= 0;
            for (int a = 0; a < 64; a++) mem_arr[a] <= init_val(a);
        end else if (!(mem_read | mem_write)) begin
            mem_cnt  <= 0;
            busy_cur <= rand_busy ? int'($urandom_range(0, 4)) : busy_cfg;
        end else begin
            mem_cnt <= mem_cnt + 1;
            if (mem_write && !mem_busywait) mem_arr[mem_address] <= mem_writedata;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b0;
        port_read = '0;
        port_write = '0;
        stuck = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    // One transfer on port p from an idle arbiter; n = negedge samples until busywait low.
    task automatic run_xfer(input int p, input bit rd, input bit wr,
                            input logic [5:0] a, input logic [31:0] d,
                            output int n, output bit rise_bw,
                            output bit s_rd, output bit s_wr,
                            output logic [5:0] s_a, output logic [31:0] s_d);
        bit done;
        @(negedge CLK);
        port_read[p] = rd;
        port_write[p] = wr;
        port_address[p*AW +: AW] = a;
        port_writedata[p*DW +: DW] = d;
        #1 rise_bw = port_busywait[p];
        n = 0; done = 1'b0;
        s_rd = 1'b0; s_wr = 1'b0; s_a = '0; s_d = '0;
        while (!done && n < 100) begin
            @(negedge CLK);
            n++;
            if (n == 1) begin
                s_rd = mem_read; s_wr = mem_write; s_a = mem_address; s_d = mem_writedata;
            end
            if (!port_busywait[p]) done = 1'b1;
        end
        port_read[p] = 1'b0;
        port_write[p] = 1'b0;
    endtask

    typedef struct {
        int          port;
        bit          rd;
        bit          wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        int          busy;
        bit          exp_mrd;
        bit          exp_mwr;
        logic [31:0] exp_rdata;
        int          exp_n;
    } vec_t;

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        vec_t vecs[8];
        int n; bit rb, s_rd, s_wr; logic [5:0] s_a; logic [31:0] s_d;
        int order[$];
        bit p1_held;
        int p1_done; bit raise_pend;

        vecs[0] = '{0, 1'b1, 1'b0, 6'h05, 32'h0,        5, 1'b1, 1'b0, 32'hDEADBEEF, 7};
        vecs[1] = '{1, 1'b0, 1'b1, 6'h3F, 32'h12345678, 3, 1'b0, 1'b1, 32'hDEADBEEF, 5};
        vecs[2] = '{1, 1'b1, 1'b0, 6'h3F, 32'h0,        0, 1'b1, 1'b0, 32'h12345678, 3};
        vecs[3] = '{0, 1'b0, 1'b1, 6'h10, 32'hCAFEF00D, 1, 1'b0, 1'b1, 32'h12345678, 3};
        vecs[4] = '{0, 1'b1, 1'b0, 6'h10, 32'h0,        2, 1'b1, 1'b0, 32'hCAFEF00D, 4};
        vecs[5] = '{1, 1'b1, 1'b0, 6'h05, 32'h0,        4, 1'b1, 1'b0, 32'hDEADBEEF, 6};
        vecs[6] = '{0, 1'b1, 1'b1, 6'h20, 32'hA5A5A5A5, 1, 1'b0, 1'b1, 32'hDEADBEEF, 3};
        vecs[7] = '{1, 1'b1, 1'b0, 6'h20, 32'h0,        0, 1'b1, 1'b0, 32'hA5A5A5A5, 3};

        RESET = 1'b0;
        port_read = '0; port_write = '0; port_address = '0; port_writedata = '0;
        #2;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_writedata", mem_writedata, 0);
        chk("rst_port_readdata", port_readdata, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_busywait", port_busywait, 0);
        @(negedge CLK);
        RESET = 1'b1;

        // table of single transfers
        for (int i = 0; i < 8; i++) begin
            busy_cfg = vecs[i].busy;
            run_xfer(vecs[i].port, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                     n, rb, s_rd, s_wr, s_a, s_d);
            chk($sformatf("v%0d_bw_rise", i), rb, 1);
            chk($sformatf("v%0d_cycles", i), n, vecs[i].exp_n);
            chk($sformatf("v%0d_mem_read", i), s_rd, vecs[i].exp_mrd);
            chk($sformatf("v%0d_mem_write", i), s_wr, vecs[i].exp_mwr);
            chk($sformatf("v%0d_mem_addr", i), s_a, vecs[i].addr);
            if (vecs[i].wr) chk($sformatf("v%0d_mem_wdata", i), s_d, vecs[i].wdata);
            chk($sformatf("v%0d_rdata", i), port_readdata, vecs[i].exp_rdata);
        end

        // watchdog: memory never completes
        stuck = 1'b1;
        run_xfer(0, 1'b1, 1'b0, 6'h07, 32'h0, n, rb, s_rd, s_wr, s_a, s_d);
        chk("to_cycles", n, TO + 1);
        chk("to_err", timeout_err, 1);
        chk("to_strobe_drop", mem_read, 0);
        chk("to_rdata_keep", port_readdata, 32'hA5A5A5A5);
        stuck = 1'b0;
        busy_cfg = 1;
        run_xfer(1, 1'b1, 1'b0, 6'h05, 32'h0, n, rb, s_rd, s_wr, s_a, s_d);
        chk("to_after_cycles", n, 3);
        chk("to_after_rdata", port_readdata, 32'hDEADBEEF);
        chk("to_sticky", timeout_err, 1);

        // async reset in the middle of an access
        busy_cfg = 10;
        @(negedge CLK);
        port_read[0] = 1'b1; port_address[0 +: AW] = 6'h05;
        repeat (3) @(negedge CLK);
        chk("mid_access_read", mem_read, 1);
        #2 RESET = 1'b0;
        #1;
        chk("arst_mem_read", mem_read, 0);
        chk("arst_mem_write", mem_write, 0);
        chk("arst_mem_address", mem_address, 0);
        chk("arst_mem_wdata", mem_writedata, 0);
        chk("arst_rdata", port_readdata, 0);
        chk("arst_timeout_err", timeout_err, 0);
        port_read = '0;
        @(negedge CLK);
        RESET = 1'b1;
        busy_cfg = 1;
        run_xfer(0, 1'b1, 1'b0, 6'h05, 32'h0, n, rb, s_rd, s_wr, s_a, s_d);
        chk("post_rst_cycles", n, 3);
        chk("post_rst_rdata", port_readdata, 32'hDEADBEEF);

        // both ports request in the same cycle right after reset
        do_reset();
        busy_cfg = 2;
        @(negedge CLK);
        port_read = 2'b11;
        port_address = {6'h02, 6'h01};
        p1_held = 1'b1;
        order.delete();
        for (int c = 0; c < 60 && order.size() < 2; c++) begin
            @(negedge CLK);
            for (int p = 0; p < 2; p++) begin
                if (port_read[p] && !port_busywait[p]) begin
                    order.push_back(p);
                    chk($sformatf("both_rdata_p%0d", p), port_readdata, init_val(p + 1));
                    port_read[p] = 1'b0;
                end else if (p == 1 && port_read[1] && order.size() == 0 && !port_busywait[1]) begin
                    p1_held = 1'b0;
                end
            end
            if (port_read[1] && !port_busywait[1]) p1_held = 1'b0;
        end
        port_read = '0;
        chk("both_count", order.size(), 2);
        chk("both_first", (order.size() > 0) ? order[0] : -1, 0);
        chk("both_second", (order.size() > 1) ? order[1] : -1, 1);
        chk("both_p1_held", p1_held, 1);

        // port0 continuous, port1 requests twice: alternation 0,1,0,1,0
        do_reset();
        busy_cfg = 1;
        @(negedge CLK);
        port_read = 2'b11;
        port_address = {6'h04, 6'h03};
        order.delete(); p1_done = 0; raise_pend = 1'b0;
        for (int c = 0; c < 100 && order.size() < 5; c++) begin
            @(negedge CLK);
            for (int p = 0; p < 2; p++) begin
                if (port_read[p] && !port_busywait[p]) begin
                    order.push_back(p);
                    if (p == 1) begin
                        port_read[1] = 1'b0;
                        p1_done++;
                        raise_pend = (p1_done < 2);
                    end
                end
            end
            if (raise_pend && !port_read[1] && port_busywait[0]) begin
                port_read[1] = 1'b1;
                raise_pend = 1'b0;
            end
        end
        port_read = '0;
        chk("alt_count", order.size(), 5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("alt_%0d", k), (order.size() > k) ? order[k] : -1, k % 2);

        // randomized two-port traffic vs shadow memory and fairness rule
        begin : rnd
            localparam int K = 25;
            bit act[2]; int gap[2]; int ndone[2]; int waitc[2];
            bit t_wr[2]; logic [5:0] t_a[2]; logic [31:0] t_d[2];
            time req_since[2]; time last_resp_t;
            int last_served; int q; bit viol; int kind; int cyc;
            logic [31:0] shadow[64]; logic [31:0] last_rd;

            do_reset();
            rand_busy = 1'b1;
            for (int a = 0; a < 64; a++) shadow[a] = init_val(a);
            last_rd = 32'h0; last_served = -1; last_resp_t = 0;
            for (int p = 0; p < 2; p++) begin
                act[p] = 0; gap[p] = 0; ndone[p] = 0; waitc[p] = 0; req_since[p] = 0;
            end
            cyc = 0;
            while (cyc < 4000 && !(ndone[0] >= K && ndone[1] >= K && !act[0] && !act[1])) begin
                @(negedge CLK);
                cyc++;
                for (int p = 0; p < 2; p++) begin
                    if (act[p]) begin
                        if (!port_busywait[p]) begin
                            q = 1 - p;
                            viol = (last_served == p) && act[q] && (req_since[q] <= last_resp_t + 10);
                            chk("rnd_rr_fair", viol, 0);
                            if (t_wr[p]) begin
                                chk("rnd_wr_keeps_rdata", port_readdata, last_rd);
                                shadow[t_a[p]] = t_d[p];
                            end else begin
                                chk("rnd_rd_data", port_readdata, shadow[t_a[p]]);
                                last_rd = shadow[t_a[p]];
                            end
                            last_served = p; last_resp_t = $time;
                            port_read[p] = 1'b0; port_write[p] = 1'b0;
                            act[p] = 0; ndone[p]++;
                            gap[p] = $urandom_range(0, 3);
                        end else begin
                            waitc[p]++;
                            if (waitc[p] > 60) begin
                                checks++; errors++;
                                $display("FAIL rnd_stall: port %0d waited %0d cycles, limit 60", p, waitc[p]);
                                port_read[p] = 1'b0; port_write[p] = 1'b0;
                                act[p] = 0; ndone[p]++;
                            end
                        end
                    end
                end
                for (int p = 0; p < 2; p++) begin
                    if (!act[p] && ndone[p] < K) begin
                        if (gap[p] == 0) begin
                            kind = $urandom_range(0, 2);
                            t_wr[p] = (kind != 0);
                            t_a[p] = 6'($urandom_range(0, 7));
                            t_d[p] = $urandom;
                            port_read[p] = (kind != 1);
                            port_write[p] = t_wr[p];
                            port_address[p*AW +: AW] = t_a[p];
                            port_writedata[p*DW +: DW] = t_d[p];
                            act[p] = 1; waitc[p] = 0; req_since[p] = $time;
                        end else begin
                            gap[p]--;
                        end
                    end
                end
            end
            chk("rnd_completed", (ndone[0] >= K && ndone[1] >= K && !act[0] && !act[1]), 1);
            port_read = '0; port_write = '0;
            rand_busy = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
